// File: rtl/byte_mem_ctrl.sv
// Byte-addressable memory with a one-request port; misaligned accesses are split
// into two beats across adjacent NB-byte words, out-of-range accesses return an error.
module byte_mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] NB_W     = (ADDR_W + 1)'(NB);
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_OFF = (ADDR_W + 1)'(NB - 1);

    typedef enum logic {IDLE, BEAT2} state_t;

    state_t              state_q, state_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    logic [NB-1:0]       cap_be_q, cap_be_d;
    logic                cap_write_q, cap_write_d;
    logic [DATA_W-1:0]   rd_acc_q, rd_acc_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                accept;
    logic [ADDR_W:0]     req_end;
    logic                range_err;
    logic                aligned;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_end   = {1'b0, req_addr} + LAST_OFF;
    assign range_err = (req_end >= DEPTH_W);
    assign aligned   = (({1'b0, req_addr} % NB_W) == '0);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // State register (also holds storage, captured request and response)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_be_q    <= '0;
            cap_write_q <= 1'b0;
            rd_acc_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_be_q    <= cap_be_d;
            cap_write_q <= cap_write_d;
            rd_acc_q    <= rd_acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !range_err && !aligned) state_d = BEAT2;
            BEAT2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [NB-1:0]     op_be;
    logic              op_write;
    logic              service;
    logic [ADDR_W:0]   lane_addr;
    logic              in_first;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        req_ready   = (state_q == IDLE);
        mem_d       = mem_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_be_d    = cap_be_q;
        cap_write_d = cap_write_q;
        rd_acc_d    = rd_acc_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lane_addr   = '0;
        in_first    = 1'b0;
        rd_word     = '0;

        op_addr  = (state_q == IDLE) ? req_addr  : cap_addr_q;
        op_wdata = (state_q == IDLE) ? req_wdata : cap_wdata_q;
        op_be    = (state_q == IDLE) ? req_be    : cap_be_q;
        op_write = (state_q == IDLE) ? req_write : cap_write_q;
        service  = (state_q == BEAT2) || (accept && !range_err);

        if (accept && range_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end

        if (service) begin
            // First beat covers lanes in the word holding op_addr; BEAT2 covers the rest
            for (int unsigned i = 0; i < NB; i++) begin
                lane_addr = {1'b0, op_addr} + (ADDR_W + 1)'(i);
                in_first  = ((lane_addr / NB_W) == ({1'b0, op_addr} / NB_W));
                if (in_first == (state_q == IDLE)) begin
                    rd_word[8*i +: 8] = mem_q[lane_addr[IDX_W-1:0]];
                    if (op_write && op_be[i])
                        mem_d[lane_addr[IDX_W-1:0]] = op_wdata[8*i +: 8];
                end
            end
            if (state_q == IDLE) begin
                if (aligned) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = op_write ? '0 : rd_word;
                end else begin
                    cap_addr_d  = req_addr;
                    cap_wdata_d = req_wdata;
                    cap_be_d    = req_be;
                    cap_write_d = req_write;
                    rd_acc_d    = rd_word;
                end
            end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = op_write ? '0 : (rd_acc_q | rd_word);
            end
        end
    end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Directed bench for byte_mem_ctrl (DATA_W=16, DEPTH=256) with hand-computed expectations.
module tb_byte_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    int n_checks;
    int n_fail;

    byte_mem_ctrl #(
        .ADDR_W (16),
        .DATA_W (16),
        .DEPTH  (256)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one request and check its response at the expected latency (1 or 2 cycles)
    task automatic do_req(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be, input int lat,
                          input logic [15:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (lat == 2) begin
            check_eq({tag, ".ready_b2"}, 32'(req_ready), 32'd0);
            check_eq({tag, ".valid_b2"}, 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, ".rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        check_eq({tag, ".err"},   32'(rsp_err),   32'(exp_err));
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.valid", 32'(rsp_valid), 32'd0);
        check_eq("rst.rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst.err",   32'(rsp_err),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst.ready", 32'(req_ready), 32'd1);

        do_req("rd10",    1'b0, 16'h0010, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);
        do_req("wr04",    1'b1, 16'h0004, 16'hBEEF, 2'b11, 1, 16'h0000, 1'b0);
        do_req("rd04",    1'b0, 16'h0004, 16'h0000, 2'b00, 1, 16'hBEEF, 1'b0);
        do_req("rd05",    1'b0, 16'h0005, 16'h0000, 2'b00, 2, 16'h00BE, 1'b0);
        do_req("wr04be1", 1'b1, 16'h0004, 16'h1234, 2'b01, 1, 16'h0000, 1'b0);
        do_req("rd04b",   1'b0, 16'h0004, 16'h0000, 2'b11, 1, 16'hBE34, 1'b0);
        do_req("wrFD",    1'b1, 16'h00FD, 16'hA1B2, 2'b11, 2, 16'h0000, 1'b0);
        do_req("rdFC",    1'b0, 16'h00FC, 16'h0000, 2'b00, 1, 16'hB200, 1'b0);
        do_req("rdFE",    1'b0, 16'h00FE, 16'h0000, 2'b00, 1, 16'h00A1, 1'b0);
        do_req("wrFF",    1'b1, 16'h00FF, 16'h5555, 2'b11, 1, 16'h0000, 1'b1);
        do_req("rdFE2",   1'b0, 16'h00FE, 16'h0000, 2'b00, 1, 16'h00A1, 1'b0);
        do_req("rd100",   1'b0, 16'h0100, 16'h0000, 2'b00, 1, 16'h0000, 1'b1);
        // Split write with disabled upper lane: only 0x07 changes
        do_req("wr07be1", 1'b1, 16'h0007, 16'h77CC, 2'b01, 2, 16'h0000, 1'b0);
        do_req("rd06",    1'b0, 16'h0006, 16'h0000, 2'b00, 1, 16'hCC00, 1'b0);
        do_req("rd08",    1'b0, 16'h0008, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);

        // Response value holds after the pulse
        @(posedge clk);
        #1;
        check_eq("hold.valid", 32'(rsp_valid), 32'd0);
        check_eq("hold.rdata", 32'(rsp_rdata), 32'h0000);

        // Back-to-back: write then read in consecutive cycles
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'h1111;
        req_be    = 2'b11;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        check_eq("b2b.wr_valid", 32'(rsp_valid), 32'd1);
        check_eq("b2b.wr_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("b2b.rd_valid", 32'(rsp_valid), 32'd1);
        check_eq("b2b.rd_rdata", 32'(rsp_rdata), 32'h1111);

        // Reset during BEAT2 aborts the access
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0011;
        req_wdata = 16'hCAFE;
        req_be    = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("abort.ready_b2", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort.valid1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort.valid2", 32'(rsp_valid), 32'd0);
        check_eq("abort.ready",  32'(req_ready), 32'd1);
        do_req("abort.rd10", 1'b0, 16'h0010, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);
        do_req("abort.rd12", 1'b0, 16'h0012, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);
        do_req("abort.rd20", 1'b0, 16'h0020, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);

        // Reset wins over a simultaneous request
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'h9999;
        req_be    = 2'b11;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("rstpri.valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req("rstpri.rd30", 1'b0, 16'h0030, 16'h0000, 2'b00, 1, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
